// File: rtl/conv3_job_sequencer.sv
// -----------------------------------------------------------------------------
// conv3_job_sequencer
//
// Purpose:
//   Streams one convolution job (data words followed by two weight words) into
//   the convolution memory, kicks the engine with a START write, polls the
//   DONE register, then reads back and streams out RESULT_NUM cumulative sums.
//   A job whose DONE bit never appears within POLL_TIMEOUT polls is abandoned
//   and the sticky o_timeout flag is raised.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_job_valid/i_job_data        job word stream in
//   o_job_ready                   job word accepted when high with valid
//   o_we/o_write_addr/o_wdata     convolution memory write port
//   o_re/o_read_addr/i_rdata      convolution memory read port (i_rdata comb.)
//   o_res_valid/o_res_data/
//   o_res_last/i_res_ready        result stream out
//   o_busy                        high unless idle in LOAD at word 0
//   o_timeout                     sticky poll-timeout flag
//   o_job_count                   completed jobs, wraps at 2^16
// -----------------------------------------------------------------------------
module conv3_job_sequencer #(
    parameter int PRECISION_WIDTH  = 4,
    parameter int VALID_ADDR_WIDTH = 14,
    parameter int DATA_WIDTH       = 32,
    parameter int KERNEL_NUM       = 8,
    parameter int POLL_TIMEOUT     = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_job_valid,
    input  logic [DATA_WIDTH-1:0]         i_job_data,
    output logic                          o_job_ready,
    output logic                          o_we,
    output logic [VALID_ADDR_WIDTH-1:0]   o_write_addr,
    output logic [DATA_WIDTH-1:0]         o_wdata,
    output logic                          o_re,
    output logic [VALID_ADDR_WIDTH-1:0]   o_read_addr,
    input  logic [DATA_WIDTH-1:0]         i_rdata,
    output logic                          o_res_valid,
    output logic [2*PRECISION_WIDTH+3:0]  o_res_data,
    output logic                          o_res_last,
    input  logic                          i_res_ready,
    output logic                          o_busy,
    output logic                          o_timeout,
    output logic [15:0]                   o_job_count
);

    localparam int GROUP_NUM  = KERNEL_NUM / 8;
    localparam int RAM_DEPTH  = 2 + 9 * GROUP_NUM;
    localparam int RESULT_NUM = 8 * GROUP_NUM;
    localparam int SUM_WIDTH  = 2 * PRECISION_WIDTH + 4;

    localparam int WIDX_W = $clog2(RAM_DEPTH + 1);
    localparam int RIDX_W = $clog2(RESULT_NUM + 1);
    localparam int PCNT_W = $clog2(POLL_TIMEOUT + 1);

    // START and DONE live in the two topmost words of the address space.
    localparam logic [VALID_ADDR_WIDTH-1:0] START_ADDR = {{(VALID_ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [VALID_ADDR_WIDTH-1:0] DONE_ADDR  = {VALID_ADDR_WIDTH{1'b1}};
    // Results sit directly after the job words.
    localparam logic [VALID_ADDR_WIDTH-1:0] RES_BASE   = VALID_ADDR_WIDTH'(RAM_DEPTH);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_POLL  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    logic [2:0]            r_state;
    logic [WIDX_W-1:0]     r_word_idx;
    logic [RIDX_W-1:0]     r_res_idx;
    logic [PCNT_W-1:0]     r_poll_cnt;
    logic                  r_timeout;
    logic [15:0]           r_job_count;
    logic [SUM_WIDTH-1:0]  r_result;

    logic w_in_load;
    logic w_job_ready;
    logic w_accept;
    logic w_word_last;
    logic w_poll_last;
    logic w_res_last;
    logic w_unused_rdata;

    assign w_in_load   = (r_state == S_LOAD);
    // Ready is withheld while reset is asserted so no word is written in a
    // cycle that reset is about to discard.
    assign w_job_ready = w_in_load && !i_rst;
    assign w_accept    = w_job_ready && i_job_valid;
    assign w_word_last = (r_word_idx == WIDX_W'(RAM_DEPTH - 1));
    assign w_poll_last = (r_poll_cnt == PCNT_W'(POLL_TIMEOUT - 1));
    assign w_res_last  = (r_res_idx == RIDX_W'(RESULT_NUM - 1));

    // Only the sum field and the DONE bit of the read word carry meaning.
    assign w_unused_rdata = ^i_rdata[DATA_WIDTH-1:SUM_WIDTH];

    // Bus and stream outputs are decoded from state; idle fields stay at zero.
    always_comb begin
        o_we         = 1'b0;
        o_write_addr = '0;
        o_wdata      = '0;
        o_re         = 1'b0;
        o_read_addr  = '0;
        o_res_valid  = 1'b0;
        o_res_data   = '0;
        o_res_last   = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    o_we         = 1'b1;
                    o_write_addr = VALID_ADDR_WIDTH'(r_word_idx);
                    o_wdata      = i_job_data;
                end
            end
            S_START: begin
                o_we         = 1'b1;
                o_write_addr = START_ADDR;
            end
            S_POLL: begin
                o_re        = 1'b1;
                o_read_addr = DONE_ADDR;
            end
            S_READ: begin
                o_re        = 1'b1;
                o_read_addr = RES_BASE + VALID_ADDR_WIDTH'(r_res_idx);
            end
            S_EMIT: begin
                o_res_valid = 1'b1;
                o_res_data  = r_result;
                o_res_last  = w_res_last;
            end
            default: begin
            end
        endcase
    end

    assign o_job_ready = w_job_ready;
    assign o_busy      = !(w_in_load && (r_word_idx == '0));
    assign o_timeout   = r_timeout;
    assign o_job_count = r_job_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_LOAD;
            r_word_idx  <= '0;
            r_res_idx   <= '0;
            r_poll_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_job_count <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_word_last) begin
                            r_word_idx <= '0;
                            r_state    <= S_START;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_POLL;
                end
                S_POLL: begin
                    // DONE wins over timeout when both land on the final poll.
                    if (i_rdata[0]) begin
                        r_res_idx  <= '0;
                        r_poll_cnt <= '0;
                        r_state    <= S_READ;
                    end else if (w_poll_last) begin
                        r_timeout  <= 1'b1;
                        r_poll_cnt <= '0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    r_result <= i_rdata[SUM_WIDTH-1:0];
                    r_state  <= S_EMIT;
                end
                S_EMIT: begin
                    if (i_res_ready) begin
                        if (w_res_last) begin
                            r_job_count <= r_job_count + 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_res_idx <= r_res_idx + 1'b1;
                            r_state   <= S_READ;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/conv3_job_sequencer.md
CONV3_JOB_SEQUENCER -- requirements
Module: conv3_job_sequencer

Interface
REQ-001 Parameters SHALL be:
- PRECISION_WIDTH, default 4: operand width.
- VALID_ADDR_WIDTH, default 14: bus address width.
- DATA_WIDTH, default 32: bus/job word width.
- KERNEL_NUM, default 8: kernels per job (multiple of 8).
- POLL_TIMEOUT, default 64: maximum number of done-polls per job.

REQ-002 Derived constants SHALL be:
- GROUP_NUM = KERNEL_NUM/8
- RAM_DEPTH = 2+9*GROUP_NUM
- RESULT_NUM = 8*GROUP_NUM
- SUM_WIDTH = 2*PRECISION_WIDTH+4
- START_ADDR = 2^VALID_ADDR_WIDTH-2
- DONE_ADDR = 2^VALID_ADDR_WIDTH-1

REQ-003 The block uses one clock; reset is synchronous and active-high.

REQ-004 Ports SHALL be:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_job_valid  in  1  job word valid
- i_job_data  in  DATA_WIDTH  job word
- o_job_ready  out  1  job word accepted when high with valid
- o_we  out  1  convolution memory write enable
- o_write_addr  out  VALID_ADDR_WIDTH  write address
- o_wdata  out  DATA_WIDTH  write data
- o_re  out  1  read enable
- o_read_addr  out  VALID_ADDR_WIDTH  read address
- i_rdata  in  DATA_WIDTH  combinational read data from convolution memory
- o_res_valid  out  1  result valid
- o_res_data  out  SUM_WIDTH  cumulative sum
- o_res_last  out  1  marks the final result of a job
- i_res_ready  in  1  result consumer ready
- o_busy  out  1  high in any state other than LOAD with word index 0
- o_timeout  out  1  sticky timeout flag
- o_job_count  out  16  completed jobs, wraps at 2^16

Function
REQ-005 The FSM SHALL have states LOAD, START, POLL, READ, EMIT.

REQ-006 LOAD: o_job_ready=1; on each valid&ready the block SHALL drive o_we=1, o_write_addr=word_idx and o_wdata=i_job_data in the same cycle, then increment word_idx.

REQ-007 Job words SHALL map to addresses 0..RAM_DEPTH-1 in arrival order: data words first, then the two weight words.

REQ-008 Accepting the word with word_idx=RAM_DEPTH-1 SHALL clear word_idx and move to START; no other condition leaves LOAD.

REQ-009 START SHALL last exactly one cycle with o_we=1, o_write_addr=START_ADDR, o_wdata=0, then move to POLL.

REQ-010 POLL: o_re=1, o_read_addr=DONE_ADDR every cycle, and poll_cnt increments.
- i_rdata[0]=1: res_idx<=0, poll_cnt<=0, move to READ.
- Otherwise, after POLL_TIMEOUT polls without done: set o_timeout, clear poll_cnt, return to LOAD, emit no results.

REQ-011 READ SHALL last one cycle with o_re=1 and o_read_addr=RAM_DEPTH+res_idx, capture i_rdata[SUM_WIDTH-1:0] into the result register, and move to EMIT.

REQ-012 EMIT: o_res_valid=1; o_res_data and o_res_last SHALL hold stable until i_res_ready. o_res_last=1 iff res_idx=RESULT_NUM-1.

REQ-013 On the EMIT handshake:
- Last result: increment o_job_count and go to LOAD.
- Otherwise: increment res_idx and go to READ.

REQ-014 Each job SHALL produce exactly RESULT_NUM results, 2 cycles per result minimum.

REQ-015 o_we and o_re SHALL never be high in the same cycle; o_we SHALL be high only in LOAD-accept and START cycles.

REQ-016 When o_we=0, o_write_addr and o_wdata SHALL be 0; when o_re=0, o_read_addr SHALL be 0.

REQ-017 o_job_ready SHALL be 0 outside LOAD; o_res_valid SHALL be 0 outside EMIT.

REQ-018 o_timeout SHALL be cleared only by reset.

Reset
REQ-019 Reset SHALL take priority over every event, abort any job in progress without a START write, and take effect at the next clock edge.

REQ-020 Reset values SHALL be:
- state=LOAD
- word_idx=0, res_idx=0, poll_cnt=0
- o_timeout=0, o_job_count=0
- result register=0
- all bus and stream outputs 0, except o_job_ready=1 after the reset cycle.

Verification
REQ-021 Single job (defaults): 11 back-to-back words D0..D10 -> writes to addresses 0..10 carrying D0..D10, one START write at 16382, polling at 16383.

REQ-022 Done after 5 polls; slave sums 1..8 at addresses 11..18 -> 8 results 1..8, o_res_last only on the 8th, o_job_count=1.

REQ-023 Backpressure: i_res_ready low for 10 cycles on result 3 -> o_res_data stable, no read of address 14 until the handshake.

REQ-024 Gapped input: i_job_valid toggling every cycle -> writes only on handshake cycles, word_idx sequence intact, START after the 11th word.

REQ-025 Timeout: done never asserted -> exactly 64 polls, o_timeout=1, no results, o_job_ready=1 next cycle, o_job_count unchanged.

REQ-026 Reset mid-job: i_rst during POLL of job 2 -> next cycle all outputs at reset values; a fresh job then completes with o_job_count=1.
